// File: rtl/lane_repacker_pkg.sv
// lane_repacker_pkg: shared helpers for the lane repacker.
// Contents: MAX_LANES bounds the lane masks that popcount accepts; lane_mask_t is that mask type.
package lane_repacker_pkg;
    localparam int MAX_LANES = 64;
    typedef logic [MAX_LANES-1:0] lane_mask_t;
    function automatic int unsigned popcount(input lane_mask_t v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) c += {31'b0, v[i]};
        return c;
    endfunction
endpackage

// File: rtl/lane_repacker_compactor.sv
// lane_repacker_compactor: squeezes the valid lanes of one beat down to lane 0 upward, keeping lane order.
// Ports: in_vd/in_data sparse beat in; comp_data dense lanes out (unused upper lanes zero); comp_cnt valid lane count.
module lane_repacker_compactor
    import lane_repacker_pkg::*;
#(
    parameter int IN_LANES = 4,
    parameter int WIDTH = 16
) (
    input  logic [IN_LANES-1:0]       in_vd,
    input  logic [IN_LANES*WIDTH-1:0] in_data,
    output logic [IN_LANES*WIDTH-1:0] comp_data,
    output logic [$clog2(IN_LANES+1)-1:0] comp_cnt
);
    always_comb begin
        int pre;
        comp_data = '0;
        pre = 0;
        // pre is the number of valid lanes below lane i, i.e. lane i's destination slot
        for (int i = 0; i < IN_LANES; i++) begin
            for (int j = 0; j <= i; j++)
                if (in_vd[i] && pre == j) comp_data[j*WIDTH +: WIDTH] = in_data[i*WIDTH +: WIDTH];
            pre += in_vd[i] ? 1 : 0;
        end
        comp_cnt = ($clog2(IN_LANES+1))'(popcount(lane_mask_t'(in_vd)));
    end
endmodule

// File: rtl/lane_repacker.sv
// lane_repacker: order-preserving packer of sparse input lanes into dense output words with flush and timeout.
// Ports: clk/rst (sync, active-high); flush; in_vd/in_data/in_ready input beats; out_vd/out_data/out_ready
// output words (out_vd is a contiguous mask from lane 0); overflow sticky flag for beats dropped while not ready.
module lane_repacker
    import lane_repacker_pkg::*;
#(
    parameter int IN_LANES = 4,
    parameter int OUT_LANES = 4,
    parameter int WIDTH = 16,
    parameter int FLUSH_TIMEOUT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [IN_LANES-1:0]         in_vd,
    input  logic [IN_LANES*WIDTH-1:0]   in_data,
    output logic                        in_ready,
    output logic [OUT_LANES-1:0]        out_vd,
    output logic [OUT_LANES*WIDTH-1:0]  out_data,
    input  logic                        out_ready,
    output logic                        overflow
);
    localparam int DEPTH = IN_LANES + OUT_LANES;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = FLUSH_TIMEOUT > 1 ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int KW = $clog2(IN_LANES + 1);
    localparam logic [CW-1:0] OUT_C = CW'(OUT_LANES);
    localparam logic [CW-1:0] RDY_C = CW'(DEPTH - IN_LANES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_TIMEOUT > 0 ? FLUSH_TIMEOUT - 1 : 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d, mark_q, mark_d, held_n_q, held_n_d;
    logic [CW-1:0] n_calc, n_eff, pop_n, add_n, keep;
    logic [IW-1:0] idle_q, idle_d;
    logic hold_q, hold_d, ovf_q, ovf_d, acc, idle, fire;
    logic [IN_LANES*WIDTH-1:0] comp_data;
    logic [KW-1:0] comp_cnt;

    lane_repacker_compactor #(.IN_LANES(IN_LANES), .WIDTH(WIDTH)) u_compactor (
        .in_vd(in_vd),
        .in_data(in_data),
        .comp_data(comp_data),
        .comp_cnt(comp_cnt)
    );

    always_comb begin
        in_ready = count_q <= RDY_C;
        acc = |in_vd && in_ready;
        n_calc = mark_q != '0 ? (mark_q < OUT_C ? mark_q : OUT_C) : (count_q >= OUT_C ? OUT_C : '0);
        // a presented word keeps its size until taken, even if a later flush re-marks
        n_eff = hold_q ? held_n_q : n_calc;
        pop_n = (n_eff != '0 && out_ready) ? n_eff : '0;
        add_n = acc ? CW'(comp_cnt) : '0;
        keep = count_q - pop_n;
        count_d = keep + add_n;
        idle = !acc && count_q > mark_q;
        fire = FLUSH_TIMEOUT != 0 && idle && idle_q == IDLE_LAST;
        idle_d = (idle && !fire) ? idle_q + 1'b1 : '0;
        mark_d = (flush || fire) ? count_d : (mark_q > pop_n ? mark_q - pop_n : '0);
        hold_d = n_eff != '0 && !out_ready;
        held_n_d = n_eff;
        ovf_d = ovf_q || (|in_vd && !in_ready);
        overflow = ovf_q;
    end

    // head of the FIFO lives at slot 0: survivors shift down by pop_n, new lanes land right behind them
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            for (int j = 0; j < DEPTH; j++)
                if (CW'(i) < keep && CW'(j) == CW'(i) + pop_n) mem_d[i] = mem_q[j];
            for (int k = 0; k < IN_LANES; k++)
                if (acc && CW'(k) < CW'(comp_cnt) && CW'(i) == keep + CW'(k))
                    mem_d[i] = comp_data[k*WIDTH +: WIDTH];
        end
        for (int o = 0; o < OUT_LANES; o++) begin
            out_vd[o] = CW'(o) < n_eff;
            out_data[o*WIDTH +: WIDTH] = mem_q[o];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            mark_q <= '0;
            held_n_q <= '0;
            idle_q <= '0;
            hold_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            count_q <= count_d;
            mark_q <= mark_d;
            held_n_q <= held_n_d;
            idle_q <= idle_d;
            hold_q <= hold_d;
            ovf_q <= ovf_d;
        end
        mem_q <= mem_d;
    end
endmodule
